// File: rtl/jts16_bus_ctl_pkg.sv
// Shared types and helpers for the System 16 main-CPU bus controller.
package jts16_bus_pkg;

  // Bus-cycle sequencer states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    ACK  = 2'd2,
    ERR  = 2'd3
  } state_t;

  // 68000 function code for an interrupt-acknowledge cycle
  localparam logic [2:0] FC_INTACK = 3'd7;

  // A region matches when every masked address bit equals its base bit
  function automatic logic region_hit(input logic [7:0] addr,
                                      input logic [7:0] base,
                                      input logic [7:0] mask);
    return ((addr ^ base) & mask) == 8'd0;
  endfunction

endpackage

// File: rtl/jts16_bus_ctl_if.sv
// 68000-side bus bundle: the CPU (master) drives address and strobes,
// the controller (slave) returns data, DTACKn, BERRn and inta_n.
interface jts16_bus_ctl_if #(
  parameter int DW = 16
);
  logic [23:1]   A;
  logic          ASn;
  logic          UDSn;
  logic          LDSn;
  logic          RnW;
  logic          BGACKn;
  logic [2:0]    FC;
  logic [DW-1:0] cpu_din;
  logic          DTACKn;
  logic          BERRn;
  logic          inta_n;

  modport master (
    output A, ASn, UDSn, LDSn, RnW, BGACKn, FC,
    input  cpu_din, DTACKn, BERRn, inta_n
  );

  modport slave (
    input  A, ASn, UDSn, LDSn, RnW, BGACKn, FC,
    output cpu_din, DTACKn, BERRn, inta_n
  );
endinterface

// File: rtl/jts16_bus_ctl_decode.sv
// Priority decoder: finds the lowest-index region whose base/mask matches.
module jts16_bus_decode
  import jts16_bus_pkg::*;
#(
  parameter int NCH = 8,
  parameter int SW  = 3
) (
  input  logic [7:0]       i_addr,
  input  logic [NCH*8-1:0] i_base,
  input  logic [NCH*8-1:0] i_mask,
  output logic             o_hit,
  output logic [SW-1:0]    o_idx
);

  // Scan from the top down so the lowest matching index overwrites the rest
  always_comb begin
    o_hit = 1'b0;
    o_idx = {SW{1'b0}};
    for (int i = NCH - 1; i >= 0; i--) begin
      if (region_hit(i_addr, i_base[i*8 +: 8], i_mask[i*8 +: 8])) begin
        o_hit = 1'b1;
        o_idx = SW'(i);
      end else begin
        o_hit = o_hit;
      end
    end
  end

endmodule

// File: rtl/jts16_bus_ctl.sv
// 68000 main-CPU bus controller: region decode, wait states, ok handshake,
// bus-error timeout and interrupt-acknowledge detection.
module jts16_bus_ctl
  import jts16_bus_pkg::*;
#(
  parameter int NCH        = 8,
  parameter int DW         = 16,
  parameter int TOUTW      = 8,
  parameter int UNMAP_BERR = 0
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              cpu_cen,
  jts16_bus_ctl_if.slave    bus,
  input  logic [NCH*8-1:0]  reg_base,
  input  logic [NCH*8-1:0]  reg_mask,
  input  logic [NCH*4-1:0]  reg_wait,
  input  logic [NCH-1:0]    reg_ok,
  input  logic [NCH-1:0]    reg_wqual,
  input  logic [NCH-1:0]    ok_in,
  input  logic [NCH*DW-1:0] din_bus,
  output logic [NCH-1:0]    cs
);

  localparam int SW = (NCH > 1) ? $clog2(NCH) : 1;
  // Value one short of saturation: the tick that reaches all-ones fires BERRn
  localparam logic [TOUTW-1:0] TOUT_LAST = {{(TOUTW-1){1'b1}}, 1'b0};

  state_t           r_state, w_state;
  logic [SW-1:0]    r_sel, w_sel;
  logic [3:0]       r_cnt, w_cnt;
  logic [TOUTW-1:0] r_tout, w_tout;
  logic [NCH-1:0]   r_cs, w_cs;
  logic [DW-1:0]    r_din, w_din;
  logic             r_dtack_n, w_dtack_n;
  logic             r_berr_n, w_berr_n;
  logic             r_inta_n, w_inta_n;

  logic             w_hit;
  logic [SW-1:0]    w_idx;
  logic [DW-1:0]    w_dbus [NCH];
  logic [3:0]       w_wait [NCH];
  logic             w_start;
  logic             w_unused;

  // Only A[23:16] take part in decoding
  assign w_unused = &{1'b0, bus.A[15:1]};

  jts16_bus_decode #(.NCH(NCH), .SW(SW)) u_decode (
    .i_addr (bus.A[23:16]),
    .i_base (reg_base),
    .i_mask (reg_mask),
    .o_hit  (w_hit),
    .o_idx  (w_idx)
  );

  // Unpack the flat per-region buses for indexed access
  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      w_dbus[i] = din_bus[i*DW +: DW];
      w_wait[i] = reg_wait[i*4 +: 4];
    end
  end

  // A new cycle starts on a cpu_cen tick with our own, non-IACK address strobe
  assign w_start = cpu_cen & ~bus.ASn & bus.BGACKn & (bus.FC != FC_INTACK);

  // Next-state and next-output logic of the bus-cycle sequencer
  always_comb begin
    w_state   = r_state;
    w_sel     = r_sel;
    w_cnt     = r_cnt;
    w_tout    = r_tout;
    w_cs      = r_cs;
    w_din     = r_din;
    w_dtack_n = r_dtack_n;
    w_berr_n  = r_berr_n;
    w_inta_n  = r_inta_n;

    // IACK is answered through VPAn, so only inta_n is flagged here
    if (bus.ASn) begin
      w_inta_n = 1'b1;
    end else if (cpu_cen && r_state == IDLE && bus.BGACKn && bus.FC == FC_INTACK) begin
      w_inta_n = 1'b0;
    end else begin
      w_inta_n = r_inta_n;
    end

    case (r_state)
      IDLE: begin
        if (w_start) begin
          if (w_hit) begin
            w_sel   = w_idx;
            w_cnt   = w_wait[w_idx];
            w_tout  = {TOUTW{1'b0}};
            w_cs    = {{(NCH-1){1'b0}}, 1'b1} << w_idx;
            w_state = WAIT;
          end else if (UNMAP_BERR != 0) begin
            w_berr_n = 1'b0;
            w_state  = ERR;
          end else begin
            w_din     = {DW{1'b1}};
            w_dtack_n = 1'b0;
            w_state   = ACK;
          end
        end else begin
          w_state = IDLE;
        end
      end
      WAIT: begin
        // An aborted cycle leaves without DTACK on any clk
        if (bus.ASn) begin
          w_cs    = {NCH{1'b0}};
          w_cnt   = 4'd0;
          w_tout  = {TOUTW{1'b0}};
          w_state = IDLE;
        end else if (cpu_cen) begin
          if (r_cnt != 4'd0) begin
            w_cnt = r_cnt - 4'd1;
          end else if (!reg_ok[r_sel] || ok_in[r_sel]) begin
            w_dtack_n = 1'b0;
            w_din     = w_dbus[r_sel];
            w_state   = ACK;
          end else if (r_tout == TOUT_LAST) begin
            w_tout   = r_tout + {{(TOUTW-1){1'b0}}, 1'b1};
            w_berr_n = 1'b0;
            w_state  = ERR;
          end else begin
            w_tout = r_tout + {{(TOUTW-1){1'b0}}, 1'b1};
          end
        end else begin
          w_state = WAIT;
        end
      end
      ACK, ERR: begin
        if (bus.ASn) begin
          w_dtack_n = 1'b1;
          w_berr_n  = 1'b1;
          w_cs      = {NCH{1'b0}};
          w_cnt     = 4'd0;
          w_tout    = {TOUTW{1'b0}};
          w_state   = IDLE;
        end else begin
          w_state = r_state;
        end
      end
      default: begin
        w_state = IDLE;
      end
    endcase
  end

  // Sequencer and output registers
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state   <= IDLE;
      r_sel     <= {SW{1'b0}};
      r_cnt     <= 4'd0;
      r_tout    <= {TOUTW{1'b0}};
      r_cs      <= {NCH{1'b0}};
      r_din     <= {DW{1'b1}};
      r_dtack_n <= 1'b1;
      r_berr_n  <= 1'b1;
      r_inta_n  <= 1'b1;
    end else begin
      r_state   <= w_state;
      r_sel     <= w_sel;
      r_cnt     <= w_cnt;
      r_tout    <= w_tout;
      r_cs      <= w_cs;
      r_din     <= w_din;
      r_dtack_n <= w_dtack_n;
      r_berr_n  <= w_berr_n;
      r_inta_n  <= w_inta_n;
    end
  end

  // Write-qualified regions keep cs low until a data strobe is active
  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      cs[i] = r_cs[i] & (bus.RnW | ~reg_wqual[i] | ~bus.UDSn | ~bus.LDSn);
    end
  end

  assign bus.cpu_din = r_din;
  assign bus.DTACKn  = r_dtack_n;
  assign bus.BERRn   = r_berr_n;
  assign bus.inta_n  = r_inta_n;

endmodule

// File: tb/tb_jts16_bus_ctl.sv
// Directed self-checking bench for jts16_bus_ctl (TOUTW=4, UNMAP_BERR=0).
module tb_jts16_bus_ctl;

  logic         clk;
  logic         rstn;
  logic         cpu_cen;
  logic [63:0]  reg_base;
  logic [63:0]  reg_mask;
  logic [31:0]  reg_wait;
  logic [7:0]   reg_ok;
  logic [7:0]   reg_wqual;
  logic [7:0]   ok_in;
  logic [127:0] din_bus;
  logic [7:0]   cs;
  int           n_tests;
  int           n_fail;

  jts16_bus_ctl_if #(.DW(16)) bus ();

  jts16_bus_ctl #(.NCH(8), .DW(16), .TOUTW(4), .UNMAP_BERR(0)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .cpu_cen   (cpu_cen),
    .bus       (bus),
    .reg_base  (reg_base),
    .reg_mask  (reg_mask),
    .reg_wait  (reg_wait),
    .reg_ok    (reg_ok),
    .reg_wqual (reg_wqual),
    .ok_in     (ok_in),
    .din_bus   (din_bus),
    .cs        (cs)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One cpu_cen tick followed by one clk without cen; returns on a negedge
  task automatic tick();
    @(negedge clk);
    cpu_cen = 1'b1;
    @(negedge clk);
    cpu_cen = 1'b0;
  endtask

  // One clk without cpu_cen
  task automatic clk1();
    @(negedge clk);
    cpu_cen = 1'b0;
    @(negedge clk);
  endtask

  task automatic start(input logic [23:0] addr, input logic rnw, input logic strb_n);
    bus.A    = addr[23:1];
    bus.RnW  = rnw;
    bus.UDSn = strb_n;
    bus.LDSn = strb_n;
    bus.ASn  = 1'b0;
  endtask

  task automatic release_bus();
    bus.ASn  = 1'b1;
    bus.UDSn = 1'b1;
    bus.LDSn = 1'b1;
    bus.RnW  = 1'b1;
    bus.FC   = 3'd5;
  endtask

  task automatic test_reset();
    n_tests++;
    if (cs !== 8'h00 || bus.DTACKn !== 1'b1 || bus.BERRn !== 1'b1 || bus.inta_n !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_ctl: cs=%h dtack=%b berr=%b inta=%b exp 00/1/1/1", cs, bus.DTACKn, bus.BERRn, bus.inta_n);
    end
    n_tests++;
    if (bus.cpu_din !== 16'hFFFF) begin
      n_fail++;
      $display("FAIL reset_din: got %h exp FFFF", bus.cpu_din);
    end
  endtask

  task automatic test_read0();
    start(24'h001000, 1'b1, 1'b0);
    tick();
    n_tests++;
    if (cs !== 8'h01 || bus.DTACKn !== 1'b1) begin
      n_fail++;
      $display("FAIL read0_cs: cs=%h dtack=%b exp 01/1", cs, bus.DTACKn);
    end
    tick();
    n_tests++;
    if (bus.DTACKn !== 1'b0 || bus.cpu_din !== 16'h10AB) begin
      n_fail++;
      $display("FAIL read0_ack: dtack=%b din=%h exp 0/10AB", bus.DTACKn, bus.cpu_din);
    end
    release_bus();
    clk1();
    n_tests++;
    if (bus.DTACKn !== 1'b1 || cs !== 8'h00 || bus.cpu_din !== 16'h10AB) begin
      n_fail++;
      $display("FAIL read0_end: dtack=%b cs=%h din=%h exp 1/00/10AB", bus.DTACKn, cs, bus.cpu_din);
    end
  endtask

  task automatic test_unmapped();
    start(24'hE00000, 1'b1, 1'b0);
    tick();
    n_tests++;
    if (bus.DTACKn !== 1'b0 || bus.cpu_din !== 16'hFFFF || cs !== 8'h00 || bus.BERRn !== 1'b1) begin
      n_fail++;
      $display("FAIL unmapped: dtack=%b din=%h cs=%h berr=%b exp 0/FFFF/00/1", bus.DTACKn, bus.cpu_din, cs, bus.BERRn);
    end
    release_bus();
    clk1();
    n_tests++;
    if (bus.DTACKn !== 1'b1) begin
      n_fail++;
      $display("FAIL unmapped_end: dtack=%b exp 1", bus.DTACKn);
    end
  endtask

  task automatic test_ok();
    start(24'hC70000, 1'b1, 1'b0);
    tick();
    ok_in[2] = 1'b1;
    tick();
    ok_in[2] = 1'b0;
    n_tests++;
    if (bus.DTACKn !== 1'b1) begin
      n_fail++;
      $display("FAIL ok_countdown_pulse: dtack=%b exp 1", bus.DTACKn);
    end
    for (int k = 0; k < 5; k++) begin
      tick();
      n_tests++;
      if (bus.DTACKn !== 1'b1 || cs !== 8'h04) begin
        n_fail++;
        $display("FAIL ok_blocked[%0d]: dtack=%b cs=%h exp 1/04", k, bus.DTACKn, cs);
      end
    end
    ok_in[2] = 1'b1;
    tick();
    n_tests++;
    if (bus.DTACKn !== 1'b0 || bus.cpu_din !== 16'h30AB) begin
      n_fail++;
      $display("FAIL ok_ack: dtack=%b din=%h exp 0/30AB", bus.DTACKn, bus.cpu_din);
    end
    ok_in[2] = 1'b0;
    release_bus();
    clk1();
  endtask

  task automatic test_wqual();
    start(24'h400000, 1'b0, 1'b1);
    tick();
    n_tests++;
    if (cs !== 8'h00) begin
      n_fail++;
      $display("FAIL wqual_held: cs=%h exp 00", cs);
    end
    bus.UDSn = 1'b0;
    #1;
    n_tests++;
    if (cs !== 8'h02) begin
      n_fail++;
      $display("FAIL wqual_strobe: cs=%h exp 02", cs);
    end
    tick();
    tick();
    n_tests++;
    if (bus.DTACKn !== 1'b1) begin
      n_fail++;
      $display("FAIL wqual_wait: dtack=%b exp 1", bus.DTACKn);
    end
    tick();
    n_tests++;
    if (bus.DTACKn !== 1'b0) begin
      n_fail++;
      $display("FAIL wqual_ack: dtack=%b exp 0", bus.DTACKn);
    end
    release_bus();
    clk1();
  endtask

  task automatic test_timeout();
    start(24'hC80000, 1'b1, 1'b0);
    tick();
    for (int k = 1; k <= 14; k++) begin
      tick();
      n_tests++;
      if (bus.BERRn !== 1'b1 || bus.DTACKn !== 1'b1) begin
        n_fail++;
        $display("FAIL tout_pending[%0d]: berr=%b dtack=%b exp 1/1", k, bus.BERRn, bus.DTACKn);
      end
    end
    tick();
    n_tests++;
    if (bus.BERRn !== 1'b0 || bus.DTACKn !== 1'b1) begin
      n_fail++;
      $display("FAIL tout_fire: berr=%b dtack=%b exp 0/1", bus.BERRn, bus.DTACKn);
    end
    tick();
    tick();
    n_tests++;
    if (bus.BERRn !== 1'b0 || bus.DTACKn !== 1'b1) begin
      n_fail++;
      $display("FAIL tout_hold: berr=%b dtack=%b exp 0/1", bus.BERRn, bus.DTACKn);
    end
    release_bus();
    clk1();
    n_tests++;
    if (bus.BERRn !== 1'b1 || bus.DTACKn !== 1'b1 || cs !== 8'h00) begin
      n_fail++;
      $display("FAIL tout_end: berr=%b dtack=%b cs=%h exp 1/1/00", bus.BERRn, bus.DTACKn, cs);
    end
  endtask

  task automatic test_iack();
    bus.FC = 3'd7;
    start(24'hFFFFF0, 1'b1, 1'b0);
    tick();
    tick();
    n_tests++;
    if (bus.inta_n !== 1'b0 || cs !== 8'h00 || bus.DTACKn !== 1'b1) begin
      n_fail++;
      $display("FAIL iack: inta=%b cs=%h dtack=%b exp 0/00/1", bus.inta_n, cs, bus.DTACKn);
    end
    release_bus();
    clk1();
    n_tests++;
    if (bus.inta_n !== 1'b1) begin
      n_fail++;
      $display("FAIL iack_end: inta=%b exp 1", bus.inta_n);
    end
  endtask

  task automatic test_reset_mid();
    start(24'h400000, 1'b1, 1'b0);
    tick();
    n_tests++;
    if (cs !== 8'h02) begin
      n_fail++;
      $display("FAIL rstmid_cs: cs=%h exp 02", cs);
    end
    rstn = 1'b0;
    #1;
    n_tests++;
    if (cs !== 8'h00 || bus.DTACKn !== 1'b1 || bus.cpu_din !== 16'hFFFF) begin
      n_fail++;
      $display("FAIL rstmid_async: cs=%h dtack=%b din=%h exp 00/1/FFFF", cs, bus.DTACKn, bus.cpu_din);
    end
    release_bus();
    @(negedge clk);
    rstn = 1'b1;
    clk1();
    start(24'h001000, 1'b1, 1'b0);
    tick();
    n_tests++;
    if (cs !== 8'h01 || bus.DTACKn !== 1'b1) begin
      n_fail++;
      $display("FAIL rstmid_next_cs: cs=%h dtack=%b exp 01/1", cs, bus.DTACKn);
    end
    tick();
    n_tests++;
    if (bus.DTACKn !== 1'b0 || bus.cpu_din !== 16'h10AB) begin
      n_fail++;
      $display("FAIL rstmid_next_ack: dtack=%b din=%h exp 0/10AB", bus.DTACKn, bus.cpu_din);
    end
    release_bus();
    clk1();
  endtask

  initial begin
    n_tests   = 0;
    n_fail    = 0;
    rstn      = 1'b0;
    cpu_cen   = 1'b0;
    bus.A     = 23'd0;
    bus.BGACKn = 1'b1;
    release_bus();
    reg_base  = {8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hC8, 8'hC7, 8'h40, 8'h00};
    reg_mask  = {8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hC0, 8'hC0};
    reg_wait  = {4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd1, 4'd2, 4'd0};
    reg_ok    = 8'b0000_1100;
    reg_wqual = 8'b0000_0010;
    ok_in     = 8'h00;
    for (int i = 0; i < 8; i++) begin
      din_bus[i*16 +: 16] = 16'h10AB + 16'(i) * 16'h1000;
    end
    repeat (3) @(negedge clk);
    test_reset();
    rstn = 1'b1;
    clk1();
    test_read0();
    test_unmapped();
    test_ok();
    test_wqual();
    test_timeout();
    test_iack();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/jts16_bus_ctl.md
# jts16_bus_ctl

Parametrised 68000 bus controller for the System 16 family main CPU. It turns the CPU address/strobe bus into registered one-hot chip selects from a run-time region table, generates DTACKn with per-region wait states and an SDRAM `ok` handshake, and muxes read data back to the CPU. It adds a bus-error timeout and interrupt-acknowledge decoding, so System 16A/16B main-CPU wrappers share one controller and differ only in their region tables.

## Interface
Parameters:
- NCH, 8: number of decoded regions
- DW, 16: data bus width
- TOUTW, 8: timeout counter width; a bus error fires after 2^TOUTW−1 cpu_cen ticks
- UNMAP_BERR, 0: 1 means an unmapped access raises BERRn; 0 means it returns 16'hFFFF with DTACK

Ports:
- clk  in  1  system clock; single clock domain
- rstn  in  1  asynchronous, active-low reset
- cpu_cen  in  1  CPU phase-1 clock enable
- A  in  23  CPU address A[23:1]
- ASn, UDSn, LDSn, RnW  in  1 each  CPU bus strobes
- BGACKn  in  1  low means the bus is owned by another master; the controller ignores the cycle
- FC  in  3  CPU function code
- reg_base  in  NCH×8  per-region compare value for A[23:16]
- reg_mask  in  NCH×8  per-region mask; a bit set means that address bit is compared
- reg_wait  in  NCH×4  fixed wait states per region, counted in cpu_cen ticks
- reg_ok  in  NCH  1 means the region waits for its ok_in bit
- reg_wqual  in  NCH  1 means the cs is held off on writes until UDSn or LDSn is low
- ok_in  in  NCH  per-region data-ready signal
- din_bus  in  NCH×DW  per-region read data
- cs  out  NCH  one-hot chip selects
- cpu_din  out  DW  latched read data
- DTACKn, BERRn, inta_n  out  1 each

## Operation
- Decode: region i matches when `(A[23:16] ^ base_i) & mask_i == 0`. The lowest matching index wins.
- Interrupt acknowledge (FC==7 and !ASn): decodes no region. inta_n goes low, DTACKn stays high (the CPU autovectors through VPAn), and inta_n stays low until ASn goes high.
- FSM states:
  - IDLE → WAIT on a cpu_cen tick with !ASn, BGACKn high and FC!=7. Latches sel and the wait counter (cnt=reg_wait[sel]), sets the cs_r[sel] flag, clears the timeout counter.
  - WAIT:
    - each cpu_cen tick decrements cnt while cnt>0;
    - once cnt==0 and (!reg_ok[sel] or ok_in[sel]): DTACKn<=0, cpu_din<=din_bus[sel] → ACK;
    - while blocked on ok, the timeout counter increments each cpu_cen tick; when it saturates: BERRn<=0 → ERR.
  - Unmapped access (no region matches):
    - UNMAP_BERR=0: cpu_din<=FFFF, DTACKn<=0 → ACK.
    - UNMAP_BERR=1: BERRn<=0 → ERR.
  - ACK / ERR: held until ASn is sampled high on any clk. Then DTACKn<=1, BERRn<=1, cs flags cleared → IDLE.
  - ASn rising while in WAIT (aborted cycle): cs cleared, no DTACK → IDLE on the same clk.
- cs output: `cs[i] = cs_r[i] & (RnW | !reg_wqual[i] | !UDSn | !LDSn)`. This gating is combinational.
- cpu_din holds its value outside ACK. It is never driven from an unlatched source.

## Timing
- Reset values: cs=0, DTACKn=1, BERRn=1, inta_n=1, cpu_din=16'hFFFF, FSM=IDLE, counters=0.
- Zero-wait, non-ok region: ASn sampled low at cpu_cen tick N, so cs is high after N. DTACKn goes low at tick N+1.
- Wait state w: DTACKn goes low at tick N+1+w.
- ok region: DTACKn goes low at the first tick at or after N+1+w where ok_in is high.
- ok_in pulsing during the wait-state countdown is ignored. Only ok_in sampled after cnt==0 counts.
- ASn high is checked every clk, not only on cpu_cen, so back-to-back cycles lose no tick.
- Reset asserted mid-cycle: all outputs return to their reset values asynchronously.
- Region table changes are only legal while the FSM is IDLE.

## Structure
- Package jts16_bus_pkg holds:
  - the state enum (IDLE/WAIT/ACK/ERR);
  - the FC_INTACK=3'd7 constant;
  - a decode function `region_hit(addr, base, mask)`.
- Sub-module jts16_bus_decode: combinational priority encoder producing the hit flag and the index. Everything else is in the top module.

## Test plan
- Region 0 (base 00, mask C0, wait 0, no ok); read A=0x001000 → cs=0x01, DTACKn low one cpu_cen after ASn low, cpu_din=din_bus[0].
- Region 2 (base C7, mask FF, reg_ok=1), ok_in raised 5 ticks late → DTACKn low on the tick ok is sampled; the captured data matches.
- Write to a reg_wqual region with UDSn/LDSn delayed by one tick after ASn → cs stays low until a strobe falls, then goes high.
- ok_in held low with TOUTW=4 → BERRn low after 15 blocked ticks; DTACKn never asserts; both return high when ASn rises.
- IACK cycle (FC=7) → inta_n low, cs=0, DTACKn=1. Unmapped read A=0xE00000 with UNMAP_BERR=0 → cpu_din=FFFF and DTACK.
- rstn pulsed low during WAIT → cs=0, DTACKn=1, FSM=IDLE. The next access completes normally.
